// File: rtl/mmio_bridge.sv
// mmio_bridge: decodes EX_DM accesses into internal DM, one of NUM_CH external channels, or unmapped space.
// Latency: DM and unmapped accesses are 0 cycles; external accesses stall 1 + n cycles (n = WAIT cycles up to ack).
// Backpressure: cpu_stall holds the pipeline while an external request is outstanding; ch_req waits for ch_ack.
// Ports: cpu_* = memory stage side, dm_* = internal data memory, ch_* = external channels,
//        err/err_addr/err_clr = sticky error reporting.
// Optional feature: define MMIO_TIMEOUT_EN to abandon a WAIT after TIMEOUT cycles with no ack.
module mmio_bridge #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int SEL_W   = 3,
    parameter int NUM_CH  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic [DATA_W-1:0]        cpu_wdata,
    input  logic                     cpu_re,
    input  logic                     cpu_we,
    output logic [DATA_W-1:0]        cpu_rdata,
    output logic                     cpu_stall,
    output logic                     dm_re,
    output logic                     dm_we,
    input  logic [DATA_W-1:0]        dm_rdata,
    output logic [NUM_CH-1:0]        ch_req,
    output logic                     ch_we,
    output logic [ADDR_W-1:0]        ch_addr,
    output logic [DATA_W-1:0]        ch_wdata,
    input  logic [NUM_CH*DATA_W-1:0] ch_rdata,
    input  logic [NUM_CH-1:0]        ch_ack,
    input  logic                     err_clr,
    output logic                     err,
    output logic [ADDR_W-1:0]        err_addr
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     sel_q, sel_d;
    logic [ADDR_W-1:0]   ch_addr_q, ch_addr_d;
    logic [DATA_W-1:0]   ch_wdata_q, ch_wdata_d;
    logic                ch_we_q, ch_we_d;
    logic [DATA_W-1:0]   rd_q, rd_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;

    logic [SEL_W-1:0]    region;
    logic                is_dm, is_ext, access;
    logic                ext_start, ack_hit, tmo_hit;
    logic                unmapped_hit, rw_conflict, err_set;
    logic [ADDR_W-1:0]   err_src_addr;

    assign region = cpu_addr[ADDR_W-1 -: SEL_W];
    assign is_dm  = (region == '0);
    assign is_ext = !is_dm && ({1'b0, region} <= (SEL_W+1)'(NUM_CH));
    assign access = cpu_re | cpu_we;

    assign ext_start = (state_q == S_IDLE) && is_ext && access;
    // Acks from other channels, or outside WAIT, never reach the FSM.
    assign ack_hit   = (state_q == S_WAIT) && ch_ack[sel_q];

`ifdef MMIO_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts WAIT cycles; cnt_d equals the number of WAIT cycles so far including this one.
    always_comb begin
        cnt_d = '0;
        if (state_q == S_WAIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign tmo_hit = (state_q == S_WAIT) && !ack_hit && (cnt_d == CNT_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign tmo_hit        = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (ext_start) state_d = S_WAIT;
            S_WAIT:  if (ack_hit || tmo_hit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        cpu_stall = (state_q == S_WAIT) || ext_start;
        ch_req    = (state_q == S_WAIT) ? (NUM_CH'(1) << sel_q) : '0;
        dm_re     = cpu_re & is_dm;
        // A simultaneous re & we to DM is a read.
        dm_we     = cpu_we & ~cpu_re & is_dm;
        if (state_q == S_DONE) begin
            cpu_rdata = rd_q;
        end else if (is_dm) begin
            cpu_rdata = dm_rdata;
        end else begin
            cpu_rdata = '0;
        end
    end

    // Request capture, read data and sticky error
    always_comb begin
        sel_d      = sel_q;
        ch_addr_d  = ch_addr_q;
        ch_wdata_d = ch_wdata_q;
        ch_we_d    = ch_we_q;
        rd_d       = rd_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;

        if (ext_start) begin
            sel_d      = CH_W'(region - 1'b1);
            ch_addr_d  = cpu_addr;
            ch_wdata_d = cpu_wdata;
            // re & we to a channel is carried out as a write.
            ch_we_d    = cpu_we;
        end

        if (ack_hit) begin
            rd_d = ch_rdata[sel_q*DATA_W +: DATA_W];
        end else if (tmo_hit) begin
            rd_d = '1;
        end

        // A new error beats a same-cycle clear; err_addr keeps the first error only.
        if (err_set) begin
            err_d = 1'b1;
            if (!err_q) begin
                err_addr_d = err_src_addr;
            end
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    assign unmapped_hit = (state_q == S_IDLE) && access && !is_dm && !is_ext;
    assign rw_conflict  = ext_start && cpu_re && cpu_we;
    assign err_set      = unmapped_hit || rw_conflict || tmo_hit;
    assign err_src_addr = tmo_hit ? ch_addr_q : cpu_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q      <= '0;
            ch_addr_q  <= '0;
            ch_wdata_q <= '0;
            ch_we_q    <= 1'b0;
            rd_q       <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            sel_q      <= sel_d;
            ch_addr_q  <= ch_addr_d;
            ch_wdata_q <= ch_wdata_d;
            ch_we_q    <= ch_we_d;
            rd_q       <= rd_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign ch_addr  = ch_addr_q;
    assign ch_wdata = ch_wdata_q;
    assign ch_we    = ch_we_q;
    assign err      = err_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: directed vectors against mmio_bridge with hand-computed expectations.
// Latency: n/a (bench).
// Backpressure: ack timing is driven per vector to exercise stall lengths.
module tb_mmio_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata, dm_rdata;
    logic        cpu_re, cpu_we, cpu_stall, dm_re, dm_we;
    logic [3:0]  ch_req, ch_ack;
    logic        ch_we, err_clr, err;
    logic [15:0] ch_addr, ch_wdata, err_addr;
    logic [63:0] ch_rdata;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mmio_bridge dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_re(cpu_re), .cpu_we(cpu_we),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dm_re(dm_re), .dm_we(dm_we), .dm_rdata(dm_rdata),
        .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_rdata(ch_rdata), .ch_ack(ch_ack),
        .err_clr(err_clr), .err(err), .err_addr(err_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one external access. Ack on channel ch is raised in WAIT cycle n (n=0: never).
    task automatic ext_op(input string tag, input logic [15:0] a, input logic [15:0] wd,
                          input logic re, input logic we, input int ch, input int n,
                          input logic [15:0] rexp, input int stall_exp);
        int  stalls = 0;
        int  waits  = 0;
        bit  done   = 0;
        cpu_addr  = a;
        cpu_wdata = wd;
        cpu_re    = re;
        cpu_we    = we;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            if (cpu_stall) begin
                stalls++;
                if (ch_req != 4'b0) begin
                    waits++;
                    if (waits == 1) begin
                        chk({tag, ".req"},   {28'b0, ch_req}, 32'(4'b0001 << ch));
                        chk({tag, ".we"},    {31'b0, ch_we},  {31'b0, we});
                        chk({tag, ".addr"},  {16'b0, ch_addr},  {16'b0, a});
                        chk({tag, ".wdata"}, {16'b0, ch_wdata}, {16'b0, wd});
                    end
                    if (waits == n) begin
                        ch_ack[ch] = 1'b1;
                    end else if (waits == 1 && ch != 1) begin
                        ch_ack[1] = 1'b1;   // stray ack from another channel
                    end
                end
            end else begin
                done = 1;
                if (re) chk({tag, ".rdata"}, {16'b0, cpu_rdata}, {16'b0, rexp});
                chk({tag, ".req_done"}, {28'b0, ch_req}, 32'h0);
            end
            tick();
            ch_ack = 4'b0;
        end
        chk({tag, ".finished"}, {31'b0, done}, 32'h1);
        chk({tag, ".stalls"}, 32'(stalls), 32'(stall_exp));
    endtask

    task automatic idle_inputs();
        cpu_re  = 1'b0;
        cpu_we  = 1'b0;
        err_clr = 1'b0;
        ch_ack  = 4'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cpu_addr = 16'h0; cpu_wdata = 16'h0; dm_rdata = 16'h0;
        idle_inputs();
        ch_rdata = {16'h4444, 16'hA5A5, 16'h2222, 16'h1111};
        tick(); tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst.stall", {31'b0, cpu_stall}, 32'h0);
        chk("rst.req",   {28'b0, ch_req},    32'h0);
        chk("rst.we",    {31'b0, ch_we},     32'h0);
        chk("rst.addr",  {16'b0, ch_addr},   32'h0);
        chk("rst.wdata", {16'b0, ch_wdata},  32'h0);
        chk("rst.err",   {31'b0, err},       32'h0);
        chk("rst.eaddr", {16'b0, err_addr},  32'h0);
        tick();

        // Internal DM load
        cpu_addr = 16'h0040; cpu_re = 1'b1; dm_rdata = 16'h1234;
        @(negedge clk);
        chk("dm_ld.re",    {31'b0, dm_re},     32'h1);
        chk("dm_ld.we",    {31'b0, dm_we},     32'h0);
        chk("dm_ld.rdata", {16'b0, cpu_rdata}, 32'h1234);
        chk("dm_ld.stall", {31'b0, cpu_stall}, 32'h0);
        tick();
        // Internal DM store
        cpu_re = 1'b0; cpu_we = 1'b1; cpu_addr = 16'h0050;
        @(negedge clk);
        chk("dm_st.we",    {31'b0, dm_we},     32'h1);
        chk("dm_st.re",    {31'b0, dm_re},     32'h0);
        tick();
        // DM re & we: read wins, no error
        cpu_re = 1'b1;
        @(negedge clk);
        chk("dm_rw.re", {31'b0, dm_re}, 32'h1);
        chk("dm_rw.we", {31'b0, dm_we}, 32'h0);
        tick();
        idle_inputs();
        @(negedge clk);
        chk("dm_rw.err", {31'b0, err}, 32'h0);

        // Acks while idle are ignored
        ch_ack = 4'b1111;
        @(negedge clk);
        chk("idle_ack.stall", {31'b0, cpu_stall}, 32'h0);
        tick();
        ch_ack = 4'b0;
        @(negedge clk);
        chk("idle_ack.req", {28'b0, ch_req}, 32'h0);
        tick();

        // External store, ack in first WAIT cycle
        ext_op("st_ch0", 16'h2010, 16'hBEEF, 1'b0, 1'b1, 0, 1, 16'h0, 2);
        // External load, ack after 4 WAIT cycles, stray ack on ch1
        ext_op("ld_ch2", 16'h6002, 16'h0, 1'b1, 1'b0, 2, 4, 16'hA5A5, 5);
        // Back-to-back: highest channel then channel 0
        ext_op("ld_ch3", 16'h8000, 16'h0, 1'b1, 1'b0, 3, 2, 16'h4444, 3);
        ext_op("ld_ch0", 16'h2002, 16'h0, 1'b1, 1'b0, 0, 1, 16'h1111, 2);
        idle_inputs();
        @(negedge clk);
        chk("b2b.err", {31'b0, err}, 32'h0);
        tick();

        // Unmapped load
        cpu_addr = 16'hE000; cpu_re = 1'b1;
        @(negedge clk);
        chk("unm.stall", {31'b0, cpu_stall}, 32'h0);
        chk("unm.rdata", {16'b0, cpu_rdata}, 32'h0);
        chk("unm.req",   {28'b0, ch_req},    32'h0);
        chk("unm.dm_re", {31'b0, dm_re},     32'h0);
        tick();
        // Later unmapped store must not move err_addr
        cpu_re = 1'b0; cpu_we = 1'b1; cpu_addr = 16'hC000;
        @(negedge clk);
        chk("unm.err",   {31'b0, err},      32'h1);
        chk("unm.eaddr", {16'b0, err_addr}, 32'hE000);
        tick();
        idle_inputs();
        @(negedge clk);
        chk("unm2.eaddr", {16'b0, err_addr}, 32'hE000);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        chk("clr.err", {31'b0, err}, 32'h0);
        tick();
        // New error then clear colliding with another error
        cpu_addr = 16'hA000; cpu_re = 1'b1;
        tick();
        cpu_addr = 16'hC000; err_clr = 1'b1;
        tick();
        idle_inputs();
        @(negedge clk);
        chk("clr_vs_set.err",   {31'b0, err},      32'h1);
        chk("clr_vs_set.eaddr", {16'b0, err_addr}, 32'hA000);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // re & we to a channel: performed as write, flags error
        ext_op("rw_ch0", 16'h2020, 16'h5A5A, 1'b1, 1'b1, 0, 1, 16'h1111, 2);
        idle_inputs();
        @(negedge clk);
        chk("rw.err",   {31'b0, err},      32'h1);
        chk("rw.eaddr", {16'b0, err_addr}, 32'h2020);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

`ifdef MMIO_TIMEOUT_EN
        ext_op("tmo", 16'h4000, 16'h0, 1'b1, 1'b0, 1, 0, 16'hFFFF, 16);
        idle_inputs();
        @(negedge clk);
        chk("tmo.err",   {31'b0, err},      32'h1);
        chk("tmo.eaddr", {16'b0, err_addr}, 32'h4000);
`else
        ext_op("slow", 16'h4000, 16'h0, 1'b1, 1'b0, 1, 20, 16'h2222, 21);
        idle_inputs();
        @(negedge clk);
        chk("slow.err", {31'b0, err}, 32'h0);
`endif
        tick();

        // Reset in the third WAIT cycle abandons the request
        cpu_addr = 16'h2000; cpu_re = 1'b1;
        tick();
        tick();
        tick();
        @(negedge clk);
        chk("rstw.req_before", {28'b0, ch_req}, 32'h1);
        rst = 1'b1;
        cpu_re = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rstw.req",   {28'b0, ch_req},    32'h0);
        chk("rstw.stall", {31'b0, cpu_stall}, 32'h0);
        chk("rstw.err",   {31'b0, err},       32'h0);
        tick();

        // Bridge still works after the abandoned transaction
        ext_op("post_rst", 16'h6004, 16'h0, 1'b1, 1'b0, 2, 1, 16'hA5A5, 2);
        idle_inputs();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
